operand_queue: RTL and testbench

Parametrised, buffered successor to the combinational SPARC second-source-operand handler. Each accepted request computes operand N from register value R, immediate field Imm and selector IS, then stores N with a caller tag in a DEPTH-entry FIFO. The decode stage feeds the input side, and the execute stage drains the output side through a valid/ready handshake. This decouples operand formation from ALU stalls.

---
 rtl/operand_queue.sv | 126 ++++++++++++
 tb/tb_operand_queue.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/operand_queue.sv
// Forms SPARC operand N from R/Imm/IS and queues it with a tag; OPERAND_QUEUE_ILLEGAL_EN keeps IS[3] per entry.
// Latency: an entry pushed at edge t is visible on out_* after edge t when the queue was empty.
// Backpressure: in_ready = !full (no pass-through on pop when full); out_valid = !empty.
module operand_queue #(
   parameter int DW    = 32,
   parameter int IMM_W = 22,
   parameter int DEPTH = 2,
   parameter int TAG_W = 5
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DW-1:0]              R,
   input  logic [IMM_W-1:0]           Imm,
   input  logic [3:0]                 IS,
   input  logic [TAG_W-1:0]           in_tag,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DW-1:0]              out_n,
   output logic [TAG_W-1:0]           out_tag,
   output logic                       out_illegal,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef struct packed {
`ifdef OPERAND_QUEUE_ILLEGAL_EN
      logic             illegal;
`endif
      logic [TAG_W-1:0] tag;
      logic [DW-1:0]    n;
   } entry_t;

   entry_t          mem_q [DEPTH];
   entry_t          entry_d;
   entry_t          head;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]   level_q, level_d;
   logic [DW-1:0]   n_d;
   logic            full, empty, push, pop;

   // Immediate fields widened to DW before any shift so high bits fall off at DW.
   logic [DW-1:0]   sext13, sext11, sext10, sext22, zext22;
   assign sext13 = DW'($signed(Imm[12:0]));
   assign sext11 = DW'($signed(Imm[10:0]));
   assign sext10 = DW'($signed(Imm[9:0]));
   assign sext22 = DW'($signed(Imm[21:0]));
   assign zext22 = DW'(Imm[21:0]);

   always_comb begin
      n_d = '0;
      case (IS)
         4'b0000: n_d = R;
         4'b0001: n_d = sext13;
         4'b0010: n_d = zext22 << 10;
         4'b0011: n_d = sext22 << 2;
         4'b0100: n_d = DW'(R[4:0]);
         4'b0101: n_d = DW'(Imm[4:0]);
         4'b0110: n_d = sext11;
         4'b0111: n_d = sext10;
         default: n_d = '0;
      endcase
   end

   always_comb begin
      entry_d     = '0;
      entry_d.n   = n_d;
      entry_d.tag = in_tag;
`ifdef OPERAND_QUEUE_ILLEGAL_EN
      entry_d.illegal = IS[3];
`endif
   end

   assign full      = (level_q == LW'(DEPTH));
   assign empty     = (level_q == '0);
   assign in_ready  = !full;
   assign out_valid = !empty;
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Payload storage is not reset; the empty mask on the outputs hides stale data.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= entry_d;
   end

   assign head    = mem_q[rd_ptr_q];
   assign out_n   = out_valid ? head.n   : '0;
   assign out_tag = out_valid ? head.tag : '0;
   assign level   = level_q;

`ifdef OPERAND_QUEUE_ILLEGAL_EN
   assign out_illegal = out_valid & head.illegal;
`else
   assign out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_operand_queue.sv
// Directed checks of operand_queue: formats, fill/backpressure, push+pop wrap, async reset, DW=64.
module tb_operand_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, out_valid, out_ready, out_illegal;
   logic [31:0] R, out_n;
   logic [21:0] Imm;
   logic [3:0]  IS;
   logic [4:0]  in_tag, out_tag;
   logic [1:0]  level;

   logic        in_valid64, in_ready64, out_valid64, out_illegal64;
   logic [63:0] r64, out_n64;
   logic [21:0] imm64;
   logic [3:0]  is64;
   logic [4:0]  tag64, out_tag64;
   logic [1:0]  level64;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   operand_queue #(.DW(32), .IMM_W(22), .DEPTH(2), .TAG_W(5)) u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .R(R), .Imm(Imm), .IS(IS), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_n(out_n),
      .out_tag(out_tag), .out_illegal(out_illegal), .level(level)
   );

   operand_queue #(.DW(64), .IMM_W(22), .DEPTH(2), .TAG_W(5)) u_dut64 (
      .clk(clk), .reset(reset), .in_valid(in_valid64), .in_ready(in_ready64),
      .R(r64), .Imm(imm64), .IS(is64), .in_tag(tag64),
      .out_valid(out_valid64), .out_ready(1'b1), .out_n(out_n64),
      .out_tag(out_tag64), .out_illegal(out_illegal64), .level(level64)
   );

`ifdef OPERAND_QUEUE_ILLEGAL_EN
   localparam logic ILL_EXP = 1'b1;
`else
   localparam logic ILL_EXP = 1'b0;
`endif

   task automatic test_reset();
      reset = 1'b1;
      #3;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
      total++; if (out_n !== 32'h0) begin bad++; $display("FAIL rst_out_n got=%h exp=0", out_n); end
      total++; if (out_tag !== 5'h0) begin bad++; $display("FAIL rst_out_tag got=%h exp=0", out_tag); end
      total++; if (out_illegal !== 1'b0) begin bad++; $display("FAIL rst_out_illegal got=%b exp=0", out_illegal); end
      total++; if (level !== 2'd0) begin bad++; $display("FAIL rst_level got=%0d exp=0", level); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_formats();
      logic [3:0]  is_t  [10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                                  4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b0001};
      logic [21:0] imm_t [10] = '{22'h231113, 22'h231113, 22'h231113, 22'h231113, 22'h231113,
                                  22'h231113, 22'h000400, 22'h231113, 22'h231113, 22'h230113};
      logic [31:0] exp_t [10] = '{32'hE0000003, 32'hFFFFF113, 32'h8C444C00, 32'hFF8C444C, 32'h00000003,
                                  32'h00000013, 32'hFFFFFC00, 32'h00000113, 32'h00000000, 32'h00000113};
      logic        ill_exp;
      out_ready = 1'b1;
      R = 32'hE0000003;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; IS = is_t[i]; Imm = imm_t[i]; in_tag = 5'(i);
         @(posedge clk); @(negedge clk);
         in_valid = 1'b0; IS = 4'hF; Imm = '0; in_tag = '0;
         ill_exp = is_t[i][3] ? ILL_EXP : 1'b0;
         total++; if (out_n !== exp_t[i]) begin bad++; $display("FAIL fmt%0d_n IS=%b got=%h exp=%h", i, is_t[i], out_n, exp_t[i]); end
         total++; if (out_tag !== 5'(i)) begin bad++; $display("FAIL fmt%0d_tag got=%0d exp=%0d", i, out_tag, i); end
         total++; if (out_illegal !== ill_exp) begin bad++; $display("FAIL fmt%0d_illegal got=%b exp=%b", i, out_illegal, ill_exp); end
         @(posedge clk); @(negedge clk);
         total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fmt%0d_drained got=%b exp=0", i, out_valid); end
      end
   endtask

   task automatic test_fill();
      out_ready = 1'b0; IS = 4'b0000; R = 32'h0;
      in_valid = 1'b1; in_tag = 5'd1;
      @(posedge clk); @(negedge clk);
      total++; if (level !== 2'd1 || in_ready !== 1'b1) begin bad++; $display("FAIL fill_1 level=%0d in_ready=%b exp 1/1", level, in_ready); end
      in_tag = 5'd2;
      @(posedge clk); @(negedge clk);
      in_tag = 5'd3;
      total++; if (level !== 2'd2 || in_ready !== 1'b0) begin bad++; $display("FAIL fill_2 level=%0d in_ready=%b exp 2/0", level, in_ready); end
      @(posedge clk); @(negedge clk);
      total++; if (level !== 2'd2 || out_tag !== 5'd1) begin bad++; $display("FAIL fill_held level=%0d tag=%0d exp 2/1", level, out_tag); end
      out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      total++; if (level !== 2'd1 || out_tag !== 5'd2 || in_ready !== 1'b1) begin
         bad++; $display("FAIL fill_pop1 level=%0d tag=%0d in_ready=%b exp 1/2/1", level, out_tag, in_ready); end
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      total++; if (level !== 2'd1 || out_tag !== 5'd3) begin bad++; $display("FAIL fill_pop2 level=%0d tag=%0d exp 1/3", level, out_tag); end
      @(posedge clk); @(negedge clk);
      total++; if (level !== 2'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL fill_empty level=%0d out_valid=%b exp 0/0", level, out_valid); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0; in_valid = 1'b1; in_tag = 5'd10;
      @(posedge clk); @(negedge clk);
      out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         in_tag = 5'(11 + k);
         total++; if (level !== 2'd1 || out_tag !== 5'(10 + k)) begin
            bad++; $display("FAIL b2b_%0d level=%0d tag=%0d exp 1/%0d", k, level, out_tag, 10 + k); end
         @(posedge clk); @(negedge clk);
      end
      in_valid = 1'b0;
      total++; if (level !== 2'd1 || out_tag !== 5'd20) begin bad++; $display("FAIL b2b_last level=%0d tag=%0d exp 1/20", level, out_tag); end
      @(posedge clk); @(negedge clk);
      total++; if (level !== 2'd0) begin bad++; $display("FAIL b2b_drain level=%0d exp 0", level); end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0; in_valid = 1'b1; in_tag = 5'd4;
      @(posedge clk); @(negedge clk);
      in_tag = 5'd5;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      total++; if (level !== 2'd2) begin bad++; $display("FAIL rmid_pre level=%0d exp 2", level); end
      #2 reset = 1'b1;
      #1;
      total++; if (out_valid !== 1'b0 || level !== 2'd0 || in_ready !== 1'b1 || out_tag !== 5'd0) begin
         bad++; $display("FAIL rmid_async out_valid=%b level=%0d in_ready=%b tag=%0d exp 0/0/1/0", out_valid, level, in_ready, out_tag); end
      @(negedge clk);
      reset = 1'b0;
      in_valid = 1'b1; in_tag = 5'd7; out_ready = 1'b1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_before_edge out_valid=%b exp 0", out_valid); end
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1 || out_tag !== 5'd7 || level !== 2'd1) begin
         bad++; $display("FAIL rmid_first out_valid=%b tag=%0d level=%0d exp 1/7/1", out_valid, out_tag, level); end
      @(posedge clk); @(negedge clk);
   endtask

   task automatic test_dw64();
      in_valid64 = 1'b1; is64 = 4'b0011; imm64 = 22'h200000; tag64 = 5'd9; r64 = 64'h0;
      @(posedge clk); @(negedge clk);
      in_valid64 = 1'b0;
      // sext(0x200000) = ...FFE00000; shifted left by 2 gives ...FF800000
      total++; if (out_n64 !== 64'hFFFFFFFFFF800000 || out_tag64 !== 5'd9) begin
         bad++; $display("FAIL dw64_disp22 got=%h tag=%0d exp=ffffffffff800000/9", out_n64, out_tag64); end
      in_valid64 = 1'b1; is64 = 4'b0010; imm64 = 22'h3FFFFF; tag64 = 5'd10;
      @(posedge clk); @(negedge clk);
      in_valid64 = 1'b0;
      total++; if (out_n64 !== 64'h00000000FFFFFC00) begin
         bad++; $display("FAIL dw64_sethi got=%h exp=00000000fffffc00", out_n64); end
      @(posedge clk); @(negedge clk);
   endtask

   initial begin
      in_valid = 1'b0; out_ready = 1'b0; R = '0; Imm = '0; IS = '0; in_tag = '0;
      in_valid64 = 1'b0; r64 = '0; imm64 = '0; is64 = '0; tag64 = '0;
      test_reset();
      test_formats();
      test_fill();
      test_back_to_back();
      test_reset_mid();
      test_dw64();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
